// File: rtl/xgmii_rx_framer.sv
// xgmii_rx_framer: turns decoded 64b/66b block flags plus payload bytes back
// into x(l)gmii data/control words (/I/ 0x07, /S/ 0xFB, /T/ 0xFD, /E/ 0xFE).
// Optional statistics counters are built when XGMII_RX_FRAMER_STATS_EN is
// defined; without it the ports and counter logic are absent and the
// datapath is unchanged.
module xgmii_rx_framer #(
  parameter int IS_40G      = 1,
  parameter int DATA_W      = 64,
  parameter int KEEP_W      = DATA_W/8,
  parameter int LANE0_CNT_N = IS_40G ? 1 : 2,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   valid_i,
  input  logic                   ctrl_v_i,
  input  logic                   idle_v_i,
  input  logic                   term_v_i,
  input  logic                   err_v_i,
  input  logic [LANE0_CNT_N-1:0] start_v_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic [KEEP_W-1:0]      keep_i,
  output logic [DATA_W-1:0]      xgmii_rxd_o,
  output logic [KEEP_W-1:0]      xgmii_rxc_o,
  output logic                   xgmii_v_o
`ifdef XGMII_RX_FRAMER_STATS_EN
  ,
  output logic [CNT_W-1:0]       frame_cnt_o,
  output logic [CNT_W-1:0]       err_cnt_o
`endif
);

  localparam int HALF = KEEP_W/2;
  localparam logic [DATA_W-1:0] IDLE_WORD = {KEEP_W{8'h07}};
  localparam logic [DATA_W-1:0] ERR_WORD  = {KEEP_W{8'hFE}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  state_t              state;
  state_t              nxt_state;
  logic [DATA_W-1:0]   nxt_rxd;
  logic [KEEP_W-1:0]   nxt_rxc;
  logic [DATA_W-1:0]   data_shift;
  logic [KEEP_W-1:0]   keep_inc;
  logic [KEEP_W-1:0]   fd_lane;
  logic                keep_thermo;
  logic                keep_full;
  logic                start_lo;
  logic                start_hi;
  logic [DATA_W-1:0]   term_rxd;
  logic [KEEP_W-1:0]   term_rxc;
  logic [DATA_W-1:0]   hi_rxd;
  logic [KEEP_W-1:0]   hi_rxc;

  generate
    if (DATA_W % 8 != 0 || KEEP_W != DATA_W/8 || CNT_W < 1) begin : g_bad_cfg
      $error("xgmii_rx_framer: inconsistent DATA_W/KEEP_W/CNT_W");
    end
  endgenerate

  // The second start position only exists on the 10G (two start lane) build.
  generate
    if (IS_40G == 0 && LANE0_CNT_N > 1) begin : g_lane4
      assign start_hi = start_v_i[1];
    end else begin : g_lane0_only
      assign start_hi = 1'b0;
    end
  endgenerate

  assign start_lo = start_v_i[0];

  // Terminate blocks carry the type byte in byte 0, so payload starts at byte 1.
  assign data_shift  = data_i >> 8;
  assign keep_inc    = keep_i + KEEP_W'(1);
  assign keep_thermo = ((keep_i & keep_inc) == '0);
  assign keep_full   = &keep_i;
  // The /T/ lane is the first lane whose keep bit is clear.
  assign fd_lane     = ~keep_i & ((keep_i << 1) | KEEP_W'(1));

  // Build the terminate word and the lane-4 start word lane by lane.
  always_comb begin
    term_rxd = '0;
    term_rxc = '0;
    hi_rxd   = '0;
    hi_rxc   = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep_i[i]) begin
        term_rxd[8*i +: 8] = data_shift[8*i +: 8];
        term_rxc[i]        = 1'b0;
      end else if (fd_lane[i]) begin
        term_rxd[8*i +: 8] = 8'hFD;
        term_rxc[i]        = 1'b1;
      end else begin
        term_rxd[8*i +: 8] = 8'h07;
        term_rxc[i]        = 1'b1;
      end
      if (i < HALF) begin
        hi_rxd[8*i +: 8] = 8'h07;
        hi_rxc[i]        = 1'b1;
      end else if (i == HALF) begin
        hi_rxd[8*i +: 8] = 8'hFB;
        hi_rxc[i]        = 1'b1;
      end else begin
        hi_rxd[8*i +: 8] = data_i[8*i +: 8];
        hi_rxc[i]        = 1'b0;
      end
    end
  end

  // Decode the block flags against the current state; err_v_i wins over all.
  always_comb begin
    nxt_state = state;
    nxt_rxd   = IDLE_WORD;
    nxt_rxc   = '1;
    if (err_v_i) begin
      nxt_rxd   = ERR_WORD;
      nxt_rxc   = '1;
      nxt_state = state;
    end else if (state == ST_IDLE) begin
      if (start_lo) begin
        nxt_rxd   = {data_i[DATA_W-1:8], 8'hFB};
        nxt_rxc   = KEEP_W'(1);
        nxt_state = ST_FRAME;
      end else if (start_hi) begin
        nxt_rxd   = hi_rxd;
        nxt_rxc   = hi_rxc;
        nxt_state = ST_FRAME;
      end else if (!ctrl_v_i || term_v_i) begin
        nxt_rxd   = ERR_WORD;
        nxt_rxc   = '1;
        nxt_state = ST_IDLE;
      end else if (idle_v_i) begin
        nxt_rxd   = IDLE_WORD;
        nxt_rxc   = '1;
      end else begin
        // Other control blocks between frames carry nothing for the MAC.
        nxt_rxd   = IDLE_WORD;
        nxt_rxc   = '1;
      end
    end else begin
      if (start_lo || start_hi) begin
        nxt_rxd   = ERR_WORD;
        nxt_rxc   = '1;
        nxt_state = ST_FRAME;
      end else if (term_v_i) begin
        if (!keep_thermo || keep_full) begin
          nxt_rxd = ERR_WORD;
          nxt_rxc = '1;
        end else begin
          nxt_rxd = term_rxd;
          nxt_rxc = term_rxc;
        end
        nxt_state = ST_IDLE;
      end else if (!ctrl_v_i) begin
        nxt_rxd   = data_i;
        nxt_rxc   = '0;
      end else begin
        // A control block without terminate truncates the frame.
        nxt_rxd   = ERR_WORD;
        nxt_rxc   = '1;
        nxt_state = ST_IDLE;
      end
    end
  end

  // FSM and output registers; slip cycles only drop the valid strobe.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      xgmii_rxd_o <= IDLE_WORD;
      xgmii_rxc_o <= '1;
      xgmii_v_o   <= 1'b0;
    end else begin
      xgmii_v_o <= valid_i;
      if (valid_i) begin
        state       <= nxt_state;
        xgmii_rxd_o <= nxt_rxd;
        xgmii_rxc_o <= nxt_rxc;
      end
    end
  end

`ifdef XGMII_RX_FRAMER_STATS_EN
  logic err_word;
  logic term_ok;

  // An /E/ word is the only output that is all 0xFE with every control bit set.
  assign err_word = valid_i && (&nxt_rxc) && (nxt_rxd == ERR_WORD);
  assign term_ok  = valid_i && (state == ST_FRAME) && (nxt_state == ST_IDLE) && !err_word;

  // Saturating frame and error counters.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (term_ok && !(&frame_cnt_o)) begin
        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
      end
      if (err_word && !(&err_cnt_o)) begin
        err_cnt_o <= err_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule
